// File: rtl/inst_fetch_queue_if.sv
// Fetch-unit bus: ROM address/data port plus the decode-side valid/ready head port.
// The master modport is the fetch queue itself; slave is the ROM/decode environment.
interface inst_fetch_queue_if;
   logic        ce_o;
   logic [31:0] addr_o;
   logic [31:0] inst_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   modport master (
      output ce_o, addr_o, inst_valid_o, inst_o, pc_o,
      input  inst_i, branch_flag_i, branch_target_address_i, inst_ready_i
   );

   modport slave (
      input  ce_o, addr_o, inst_valid_o, inst_o, pc_o,
      output inst_i, branch_flag_i, branch_target_address_i, inst_ready_i
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: drives the ROM, queues {pc, inst} words, drains them to decode.
// Define FETCH_DELAY_SLOT_EN to keep one branch delay-slot instruction across a redirect.
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst,
   inst_fetch_queue_if.master bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t      mem_q [DEPTH];
   logic [31:0] fpc_q, fpc_d;
   logic        ce_q;
   ptr_t        head_q, head_d, tail_q, tail_d;
   cnt_t        count_q, count_d;
   logic        full, pop, push, wr_en;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      full    = (count_q == cnt_t'(DEPTH));
      pop     = (count_q != '0) && bus.inst_ready_i;
      push    = ce_q && (!full || pop) && !bus.branch_flag_i;
      head_d  = pop ? head_q + ptr_t'(1) : head_q;
      tail_d  = tail_q;
      count_d = count_q;
      fpc_d   = fpc_q;
      wr_en   = 1'b0;
      if (bus.branch_flag_i) begin
         fpc_d = bus.branch_target_address_i & 32'hFFFF_FFFC;
`ifdef FETCH_DELAY_SLOT_EN
         // Exactly one sequential instruction after the branch survives the redirect.
         if (count_q != '0) begin
            if (pop) begin
               tail_d  = head_d;
               count_d = '0;
            end else begin
               tail_d  = head_q + ptr_t'(1);
               count_d = cnt_t'(1);
            end
         end else if (ce_q) begin
            wr_en   = 1'b1;
            tail_d  = tail_q + ptr_t'(1);
            count_d = cnt_t'(1);
         end
`else
         tail_d  = head_d;
         count_d = '0;
`endif
      end else begin
         if (push) begin
            wr_en  = 1'b1;
            tail_d = tail_q + ptr_t'(1);
            fpc_d  = fpc_q + 32'd4;
         end
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ce_q    <= 1'b0;
         fpc_q   <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ce_q    <= 1'b1;
         fpc_q   <= fpc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: queue storage is not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[tail_q] <= '{pc: fpc_q, inst: bus.inst_i};
      end
   end

   assign bus.ce_o         = ce_q;
   assign bus.addr_o       = fpc_q;
   assign bus.inst_valid_o = (count_q != '0);
   assign bus.inst_o       = bus.inst_valid_o ? mem_q[head_q].inst : 32'h0;
   assign bus.pc_o         = bus.inst_valid_o ? mem_q[head_q].pc   : 32'h0;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table for the main flow, hand sequence for PC wrap.
// Expected values follow FETCH_DELAY_SLOT_EN when the macro is defined for the build.
module tb_inst_fetch_queue;
   logic clk;
   logic rst0, rst1;
   int   checks   = 0;
   int   failures = 0;

   inst_fetch_queue_if bus0 ();
   inst_fetch_queue_if bus1 ();

   // ROM: word k holds k.
   assign bus0.inst_i = {2'b00, bus0.addr_o[31:2]};
   assign bus1.inst_i = {2'b00, bus1.addr_o[31:2]};

   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
   inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        br;
      logic [31:0] tgt;
      logic        ce;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] inst;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                               input logic ce, input logic [31:0] a, input logic vl,
                               input logic [31:0] pc, input logic [31:0] ins);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.br = br; v.tgt = tgt;
      v.ce = ce; v.addr = a; v.vld = vl; v.pc = pc; v.inst = ins;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      // rst rdy br tgt | ce addr vld pc inst  (outputs after the edge that consumed the inputs)
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h0,  0, 32'h0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h4,  1, 32'h0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h8,  1, 32'h4, 1));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'hC,  1, 32'h8, 2));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h10, 1, 32'hC, 3));
      // Reset pulse, then stall until full.
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,  0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,  0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h4,  1, 32'h0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h8,  1, 32'h0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'hC,  1, 32'h0, 0));
      for (int k = 0; k < 6; k++) vecs.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1, 32'h0, 0));
      // Resume: no gap, no duplicate.
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h14, 1, 32'h4,  1));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h18, 1, 32'h8,  2));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h1C, 1, 32'hC,  3));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h20, 1, 32'h10, 4));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h24, 1, 32'h14, 5));
      // Reset while full with a pop requested: the old entries must never reappear.
      vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,  0, 32'h0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h0,  0, 32'h0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h4,  1, 32'h0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h8,  1, 32'h4, 1));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'hC,  1, 32'h8, 2));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1, 32'h8, 2));
      vecs.push_back(mk(1, 0, 0, 0, 1, 32'h14, 1, 32'h8, 2));
`ifdef FETCH_DELAY_SLOT_EN
      // Redirect with 3 queued, no pop: head 0x8 kept as the delay slot.
      vecs.push_back(mk(1, 0, 1, 32'h100, 1, 32'h100, 1, 32'h8,   2));
      vecs.push_back(mk(1, 0, 0, 0,       1, 32'h104, 1, 32'h8,   2));
      vecs.push_back(mk(1, 1, 0, 0,       1, 32'h108, 1, 32'h100, 32'h40));
      // Redirect to 0x103 while popping: delay slot just left, queue empties.
      vecs.push_back(mk(1, 1, 1, 32'h103, 1, 32'h100, 0, 32'h0,   0));
      // Redirect with empty queue and ce_o=1: the word at 0x100 is captured.
      vecs.push_back(mk(1, 1, 1, 32'h200, 1, 32'h200, 1, 32'h100, 32'h40));
`else
      // Redirect with 3 queued: everything discarded.
      vecs.push_back(mk(1, 0, 1, 32'h100, 1, 32'h100, 0, 32'h0,   0));
      vecs.push_back(mk(1, 0, 0, 0,       1, 32'h104, 1, 32'h100, 32'h40));
      vecs.push_back(mk(1, 1, 0, 0,       1, 32'h108, 1, 32'h104, 32'h41));
      // Redirect to 0x103: low bits dropped.
      vecs.push_back(mk(1, 1, 1, 32'h103, 1, 32'h100, 0, 32'h0,   0));
      // Redirect again from an empty queue: no push that cycle.
      vecs.push_back(mk(1, 1, 1, 32'h200, 1, 32'h200, 0, 32'h0,   0));
`endif
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h204, 1, 32'h200, 32'h80));
      vecs.push_back(mk(1, 1, 0, 0, 1, 32'h208, 1, 32'h204, 32'h81));

      rst0 = 1'b0;
      rst1 = 1'b0;
      bus0.inst_ready_i = 1'b1;
      bus0.branch_flag_i = 1'b0;
      bus0.branch_target_address_i = 32'h0;
      bus1.inst_ready_i = 1'b1;
      bus1.branch_flag_i = 1'b0;
      bus1.branch_target_address_i = 32'h0;

      foreach (vecs[i]) begin
         rst0 = vecs[i].rst;
         bus0.inst_ready_i = vecs[i].rdy;
         bus0.branch_flag_i = vecs[i].br;
         bus0.branch_target_address_i = vecs[i].tgt;
         step();
         check($sformatf("v%0d_ce", i),    {31'h0, bus0.ce_o},         {31'h0, vecs[i].ce});
         check($sformatf("v%0d_addr", i),  bus0.addr_o,                vecs[i].addr);
         check($sformatf("v%0d_valid", i), {31'h0, bus0.inst_valid_o}, {31'h0, vecs[i].vld});
         check($sformatf("v%0d_pc", i),    bus0.pc_o,                  vecs[i].pc);
         check($sformatf("v%0d_inst", i),  bus0.inst_o,                vecs[i].inst);
      end

      // PC wrap from 0xFFFF_FFFC to 0 on the second instance.
      rst1 = 1'b1;
      step();
      check("wrap_ce",    {31'h0, bus1.ce_o},         32'h1);
      check("wrap_addr0", bus1.addr_o,                32'hFFFF_FFF8);
      check("wrap_vld0",  {31'h0, bus1.inst_valid_o}, 32'h0);
      step();
      check("wrap_pc0",   bus1.pc_o,   32'hFFFF_FFF8);
      check("wrap_inst0", bus1.inst_o, 32'h3FFF_FFFE);
      check("wrap_addr1", bus1.addr_o, 32'hFFFF_FFFC);
      step();
      check("wrap_pc1",   bus1.pc_o,   32'hFFFF_FFFC);
      check("wrap_inst1", bus1.inst_o, 32'h3FFF_FFFF);
      check("wrap_addr2", bus1.addr_o, 32'h0000_0000);
      step();
      check("wrap_pc2",   bus1.pc_o,   32'h0000_0000);
      check("wrap_inst2", bus1.inst_o, 32'h0000_0000);
      check("wrap_addr3", bus1.addr_o, 32'h0000_0004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end between the program counter and the IF/ID register. It generates `ce`/address for the combinational instruction ROM and captures each returned word together with its PC into a small queue. Decode drains the queue through a valid/ready handshake. Branch redirects restart fetch at a new target and discard queued wrong-path words.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 00.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `ce_o` out 1: ROM chip enable.
- `addr_o` out 32: ROM byte address (current fetch PC); bits [1:0] always 00.
- `inst_i` in 32: ROM data for `addr_o`, valid in the same cycle.
- `branch_flag_i` in 1: redirect request from ID.
- `branch_target_address_i` in 32: redirect target; bits [1:0] ignored and forced to 00.
- `inst_valid_o` out 1: head entry present.
- `inst_ready_i` in 1: decode accepts the head this cycle.
- `inst_o` out 32: head instruction; 32'h0 when `inst_valid_o`=0.
- `pc_o` out 32: head PC; 32'h0 when `inst_valid_o`=0.

## Operation
- State: `fpc` (fetch PC, drives `addr_o`), registered `ce_o`, circular queue of {pc, inst}, head/tail pointers, and count 0..DEPTH.
- pop = `inst_valid_o` & `inst_ready_i`. The handshake completes even in a redirect cycle.
- push = `ce_o` & (count<DEPTH | pop) & ~`branch_flag_i`. On push, {fpc, `inst_i`} is written at the tail and fpc is incremented by 4.
- Full queue with no pop: no push, fpc holds, and `addr_o` re-presents the same address.
- fpc wraps from 32'hFFFF_FFFC to 32'h0000_0000 (modulo-2^32 add).
- Redirect (`branch_flag_i`=1): fpc is loaded with {target[31:2],2'b00}. Queue handling depends on the configuration (below). Redirect takes priority over push.
- count next = count + push − pop. Simultaneous push and pop on a full queue is legal and count stays at DEPTH.
- Outputs `inst_o`/`pc_o`/`inst_valid_o` are read combinationally from the head registers. There is no combinational path from `inst_i` to `inst_o`.

## Timing
- While `rst`=0 at an edge, the following are registered:
  - `ce_o`=0, fpc=`RESET_PC`, count=0.
  - `inst_valid_o`=0, `inst_o`=0, `pc_o`=0.
- First edge with `rst`=1: `ce_o` becomes 1.
- Next edge: the word at `RESET_PC` is captured.
- The captured word is visible on `inst_o` in the following cycle.
- Fetch-to-output latency: 1 cycle when the queue is empty; otherwise entries are delivered in order behind the older ones.
- Sustained throughput is 1 instruction per cycle when `inst_ready_i`=1 continuously.
- A redirect asserted in cycle N means:
  - `addr_o` = target in cycle N+1.
  - The target word appears on `inst_o` in N+2 at the earliest.
- Reset asserted mid-operation flushes the queue at that edge. Any pop in the reset cycle is void.

## Configuration
- Macro `FETCH_DELAY_SLOT_EN`.
- Defined: MIPS branch delay slot is preserved. On redirect, exactly one sequential instruction after the branch survives:
  - count>0 and no pop: the head is kept and count becomes 1.
  - count>0 and pop: nothing is kept, because the delay slot was just delivered; count becomes 0.
  - count=0 and `ce_o`=1: {fpc, `inst_i`} is captured and count becomes 1.
  - count=0 and `ce_o`=0: nothing is kept.
- Undefined: a redirect discards all entries (count becomes 0) and no push occurs that cycle.

## Test plan
- Reset release, ROM word k = k, `inst_ready_i`=1:
  - `ce_o` rises 1 cycle after release.
  - `pc_o` sequence is 0x0, 0x4, 0x8… starting 2 cycles after release.
  - `inst_o` = 0,1,2…
- `inst_ready_i`=0 for 10 cycles:
  - count saturates at 4 and `addr_o` holds at 0x10.
  - On resume, `pc_o` = 0x0,0x4,0x8,0xC,0x10 with no gap or duplicate.
- Branch to 0x100 with 3 entries queued (0x8 head, no pop):
  - Without the macro, `inst_valid_o`=0 the next cycle, then `pc_o`=0x100.
  - With the macro, `pc_o`=0x8 next, then 0x100.
- Branch with target 0x103: `addr_o`=0x100 and `pc_o` of the delivered word = 0x100.
- `RESET_PC`=0xFFFF_FFF8: `pc_o` sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset pulsed (`rst`=0, one edge) while the queue is full: `inst_valid_o`=0 and `addr_o`=`RESET_PC` in the next cycle; the old entries never appear.
